vga_fetch_sched: RTL

Read-burst scheduler for the VGA frame-buffer fetch path. On each frame start it walks the frame buffer from a configured base address and issues AXI AR commands (address, len). Each burst is capped by the configured burst length, by the remaining frame bytes and by 4 KiB page boundaries. It sits between the config register file and the AXI AR channel, and uses a credit counter so the downstream pixel FIFO can never overflow.

---
 rtl/vga_fetch_pkg.sv | 23 ++
 rtl/vga_burst_calc.sv | 32 +++
 rtl/vga_fetch_sched.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types and helpers for the VGA frame-buffer fetch scheduler.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        ISSUE   = 2'd2,
        WAIT_HS = 2'd3
    } state_t;

    localparam int PageBytes = 4096;

    // Beats that fit between a beat-aligned page offset and the next 4 KiB
    // boundary. The result can reach PageBytes (offset 0, 1-byte beats), so
    // it is 13 bits wide. bb is an elaboration-time constant at every call
    // site, so the divide reduces to a shift.
    function automatic logic [12:0] beats_to_page(input logic [11:0] addr_lo, input int bb);
        logic [12:0] bytes_left;
        bytes_left = 13'(PageBytes) - {1'b0, addr_lo};
        return bytes_left / 13'(bb);
    endfunction

endpackage

// File: rtl/vga_burst_calc.sv
// Candidate burst size: the smallest of the configured burst cap, the beats
// remaining in the frame and the beats left before the next 4 KiB boundary.
module vga_burst_calc
    import vga_fetch_pkg::*;
#(
    parameter int BB        = 8,
    parameter int SizeWidth = 32
) (
    input  logic [11:0]          addr_lo_i,
    input  logic [SizeWidth-1:0] beats_left_i,
    input  logic [7:0]           burst_len_i,
    output logic [8:0]           n_o
);

    logic [12:0] w_page_beats;
    logic [8:0]  w_cap;

    assign w_page_beats = beats_to_page(addr_lo_i, BB);

    // Narrow the burst cap by page room, then by the frame remainder
    always_comb begin
        w_cap = {1'b0, burst_len_i} + 9'd1;
        if (w_page_beats < 13'(w_cap)) begin
            w_cap = w_page_beats[8:0];
        end
        if (beats_left_i < SizeWidth'(w_cap)) begin
            w_cap = beats_left_i[8:0];
        end
        n_o = w_cap;
    end

endmodule

// File: rtl/vga_fetch_sched.sv
// VGA frame-buffer read-burst scheduler: walks one frame per frame_start_i,
// issuing AXI AR commands that never cross 4 KiB and never exceed the pixel
// FIFO credit. Define VGA_FETCH_SCHED_PERF_EN to build the stall/frame counters.
module vga_fetch_sched
    import vga_fetch_pkg::*;
#(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 64,
    parameter int FifoDepth = 512,
    parameter int SizeWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 frame_start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [SizeWidth-1:0] frame_size_i,
    input  logic [7:0]           burst_len_i,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    output logic [AddrWidth-1:0] ar_addr_o,
    output logic [7:0]           ar_len_o,
    input  logic                 fifo_pop_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [31:0]          perf_stall_cnt_o,
    output logic [15:0]          perf_frame_cnt_o
);

    localparam int BB  = DataWidth / 8;
    localparam int BBW = $clog2(BB);
    localparam int SW1 = SizeWidth + 1;
    localparam int CW  = $clog2(FifoDepth + 1);
    localparam int CW1 = CW + 1;
    localparam logic [CW1-1:0] DepthExt = CW1'(FifoDepth);

    state_t               r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth-1:0] r_ar_addr;
    logic [SizeWidth-1:0] r_beats_left;
    logic [7:0]           r_burst_len;
    logic [7:0]           r_ar_len;
    logic [8:0]           r_n;
    logic [CW-1:0]        r_credit;
    logic                 r_ar_valid;
    logic                 r_frame_done;
    logic                 r_restart_pending;
    logic                 r_stop_pending;

    logic [AddrWidth-1:0] w_new_addr;
    logic [SW1-1:0]       w_size_sum;
    logic [SizeWidth-1:0] w_new_beats;
    logic                 w_fast_load;
    logic [AddrWidth-1:0] w_cur_addr;
    logic [SizeWidth-1:0] w_cur_beats;
    logic [7:0]           w_cur_burst;
    logic [8:0]           w_n;
    logic                 w_credit_ok;
    logic                 w_handshake;
    logic [CW1-1:0]       w_credit_sum;
    logic [CW-1:0]        w_credit_next;
    logic [AddrWidth-1:0] w_next_addr;
    logic [SizeWidth-1:0] w_next_beats;
    logic                 w_stop;
    logic                 w_restart;

    // Fresh frame configuration straight from the register file
    assign w_new_addr  = base_addr_i & ~AddrWidth'(BB - 1);
    assign w_size_sum  = {1'b0, frame_size_i} + SW1'(BB - 1);
    assign w_new_beats = SizeWidth'(w_size_sum >> BBW);

    // A frame start seen in ARM/ISSUE feeds the burst calculator directly so
    // the first AR can go out the very next cycle.
    assign w_fast_load = frame_start_i && enable_i && ((r_state == ARM) || (r_state == ISSUE));
    assign w_cur_addr  = w_fast_load ? w_new_addr  : r_addr;
    assign w_cur_beats = w_fast_load ? w_new_beats : r_beats_left;
    assign w_cur_burst = w_fast_load ? burst_len_i : r_burst_len;

    vga_burst_calc #(
        .BB        (BB),
        .SizeWidth (SizeWidth)
    ) u_burst_calc (
        .addr_lo_i    (w_cur_addr[11:0]),
        .beats_left_i (w_cur_beats),
        .burst_len_i  (w_cur_burst),
        .n_o          (w_n)
    );

    assign w_credit_ok = (r_credit >= CW'(w_n));
    assign w_handshake = r_ar_valid && ar_ready_i;

    // Handshake and pop in the same cycle both apply; a pop at full credit is dropped
    assign w_credit_sum  = {1'b0, r_credit}
                         - (w_handshake ? CW1'(r_n) : CW1'(0))
                         + CW1'(fifo_pop_i);
    assign w_credit_next = (w_credit_sum > DepthExt) ? CW'(FifoDepth) : w_credit_sum[CW-1:0];

    assign w_next_addr  = r_addr + (AddrWidth'(r_n) << BBW);
    assign w_next_beats = r_beats_left - SizeWidth'(r_n);
    assign w_stop       = r_stop_pending || !enable_i;
    assign w_restart    = r_restart_pending || frame_start_i;

    // Fetch FSM with registered AR command, done pulse and credit counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state           <= IDLE;
            r_addr            <= '0;
            r_beats_left      <= '0;
            r_burst_len       <= '0;
            r_ar_addr         <= '0;
            r_ar_len          <= '0;
            r_n               <= '0;
            r_credit          <= CW'(FifoDepth);
            r_ar_valid        <= 1'b0;
            r_frame_done      <= 1'b0;
            r_restart_pending <= 1'b0;
            r_stop_pending    <= 1'b0;
        end else begin
            r_credit     <= w_credit_next;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_state <= ARM;
                    end
                end
                ARM, ISSUE: begin
                    if (!enable_i) begin
                        r_state <= IDLE;
                    end else if (w_fast_load || (r_state == ISSUE)) begin
                        r_addr       <= w_cur_addr;
                        r_beats_left <= w_cur_beats;
                        r_burst_len  <= w_cur_burst;
                        if (w_cur_beats == '0) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ARM;
                        end else if (w_credit_ok) begin
                            r_ar_valid <= 1'b1;
                            r_ar_addr  <= w_cur_addr;
                            r_ar_len   <= 8'(w_n - 9'd1);
                            r_n        <= w_n;
                            r_state    <= WAIT_HS;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                WAIT_HS: begin
                    if (!enable_i) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (frame_start_i) begin
                        r_restart_pending <= 1'b1;
                    end
                    if (ar_ready_i) begin
                        r_ar_valid        <= 1'b0;
                        r_stop_pending    <= 1'b0;
                        r_restart_pending <= 1'b0;
                        r_addr            <= w_next_addr;
                        r_beats_left      <= w_next_beats;
                        if (w_stop) begin
                            r_state <= IDLE;
                        end else if (w_restart) begin
                            r_addr       <= w_new_addr;
                            r_beats_left <= w_new_beats;
                            r_burst_len  <= burst_len_i;
                            r_state      <= ISSUE;
                        end else if (w_next_beats == '0) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ARM;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ar_valid_o   = r_ar_valid;
    assign ar_addr_o    = r_ar_addr;
    assign ar_len_o     = r_ar_len;
    assign frame_done_o = r_frame_done;
    assign busy_o       = (r_state == ISSUE) || (r_state == WAIT_HS);

`ifdef VGA_FETCH_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_frame_cnt;

    // Saturating credit-stall counter and wrapping completed-frame counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_frame_cnt <= '0;
        end else begin
            if ((r_state == ISSUE) && !w_credit_ok && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (r_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_frame_cnt_o = r_frame_cnt;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_frame_cnt_o = '0;
`endif

endmodule
